// File: rtl/ppu_quant.sv
// ppu_quant: requantises accumulator vectors to INT8/INT4 lanes, global shift from a max pass or per-vector shift (VSQ)
module ppu_quant #(
  parameter int VL    = 8,
  parameter int AD    = 8,
  parameter int ACC_W = 24,
  parameter int TILES = 16,
  parameter int SH_W  = 5
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [1:0]        i_mode,
  input  logic [ACC_W*VL-1:0] i_acc_data,
  output logic              o_valid,
  output logic [8*VL-1:0]   o_data,
  output logic [SH_W-1:0]   o_sf,
  output logic              o_done
);
  localparam logic [1:0] M_INT8 = 2'd0, M_INT4 = 2'd1, M_VSQ = 2'd2;
  localparam int BW = AD > 1 ? $clog2(AD) : 1;
  localparam int TW = TILES > 1 ? $clog2(TILES) : 1;
  localparam logic [BW-1:0] B_LAST = BW'(AD - 1);
  localparam logic [TW-1:0] T_LAST = TW'(TILES - 1);
  typedef enum logic [1:0] {S_IDLE, S_MAX, S_QNT} state_t;
  state_t state;
  logic [1:0] mode;
  logic act, last, last_tile, q4, qv;
  logic [BW-1:0] beat;
  logic [TW-1:0] tile;
  logic [ACC_W-1:0] max_abs, beat_max, lv;
  logic [SH_W-1:0] cur_s;
  logic v1, dn1, q41;
  logic [SH_W-1:0] s1;
  logic [ACC_W*VL-1:0] d1;
  logic [ACC_W-1:0] ln;
  logic [ACC_W:0] rnd;
  logic signed [ACC_W:0] t, q, hi, lo;
  logic [8*VL-1:0] qd;
  // Smallest s with (x >> s) <= QMAX; x == 0 yields 0.
  function automatic logic [SH_W-1:0] calc_sh(input logic [ACC_W-1:0] x, input logic four);
    logic [SH_W-1:0] r;
    r = SH_W'(ACC_W - 1);
    for (int i = ACC_W - 1; i >= 0; i--)
      if ((x >> i) <= (four ? ACC_W'(7) : ACC_W'(127))) r = SH_W'(i);
    return r;
  endfunction
  // Most negative lane maps to 2^(ACC_W-1), which still fits as unsigned.
  always_comb begin
    beat_max = '0;
    lv = '0;
    for (int i = 0; i < VL; i++) begin
      lv = i_acc_data[i*ACC_W +: ACC_W];
      lv = lv[ACC_W-1] ? -lv : lv;
      beat_max = lv > beat_max ? lv : beat_max;
    end
  end
  assign last      = act && beat == B_LAST;
  assign last_tile = tile == T_LAST;
  assign q4        = mode == M_INT4 || mode == M_VSQ;
  assign qv        = act && state == S_QNT;
  assign cur_s     = mode == M_VSQ ? calc_sh(beat_max, 1'b1) : calc_sh(max_abs, q4);
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= S_IDLE;
      mode    <= M_INT8;
      act     <= 1'b0;
      beat    <= '0;
      tile    <= '0;
      max_abs <= '0;
    end else begin
      if (state == S_MAX && act) max_abs <= beat_max > max_abs ? beat_max : max_abs;
      if (state == S_IDLE) begin
        if (i_start) begin
          state   <= i_mode == M_VSQ ? S_QNT : S_MAX;
          mode    <= i_mode;
          act     <= 1'b1;
          beat    <= '0;
          tile    <= '0;
          max_abs <= '0;
        end
      end else if (act && !last) begin
        beat <= beat + BW'(1);
      end else if (act) begin
        beat <= '0;
        tile <= last_tile ? '0 : tile + TW'(1);
        if (last_tile) state <= state == S_MAX ? S_QNT : S_IDLE;
        act <= i_start && !(state == S_QNT && last_tile);
      end else if (i_start) begin
        act <= 1'b1;
      end
    end
  end
  // Round-half-up then arithmetic shift in ACC_W+1 bits, saturate to QMAX.
  assign rnd = s1 == '0 ? '0 : (ACC_W+1)'(1) << (s1 - 1'b1);
  assign hi  = q41 ? (ACC_W+1)'(7) : (ACC_W+1)'(127);
  assign lo  = ~hi;
  always_comb begin
    qd = '0;
    ln = '0;
    t  = '0;
    q  = '0;
    for (int i = 0; i < VL; i++) begin
      ln = d1[i*ACC_W +: ACC_W];
      t  = $signed({ln[ACC_W-1], ln}) + $signed(rnd);
      q  = t >>> s1;
      qd[i*8 +: 8] = q > hi ? hi[7:0] : q < lo ? lo[7:0] : q[7:0];
    end
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      v1      <= 1'b0;
      dn1     <= 1'b0;
      q41     <= 1'b0;
      s1      <= '0;
      d1      <= '0;
      o_valid <= 1'b0;
      o_data  <= '0;
      o_sf    <= '0;
      o_done  <= 1'b0;
    end else begin
      v1      <= qv;
      dn1     <= qv && last && last_tile;
      q41     <= q4;
      s1      <= cur_s;
      d1      <= i_acc_data;
      o_valid <= v1;
      o_data  <= v1 ? qd : '0;
      o_sf    <= v1 ? s1 : '0;
      o_done  <= v1 && dn1;
    end
  end
endmodule

// File: tb/tb_ppu_quant.sv
// tb_ppu_quant: directed matrices with hand-computed lane results, checked by a scoreboard monitor
module tb_ppu_quant;
  localparam int VL = 8, AD = 8, AW = 24, TL = 4, SW = 5;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [AW*VL-1:0] acc = '0;
  logic valid, done;
  logic [8*VL-1:0] data;
  logic [SW-1:0] sf;
  ppu_quant #(.VL(VL), .AD(AD), .ACC_W(AW), .TILES(TL), .SH_W(SW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_mode(mode), .i_acc_data(acc),
    .o_valid(valid), .o_data(data), .o_sf(sf), .o_done(done));
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  typedef struct packed {
    logic [31:0]     c;
    logic            d;
    logic [SW-1:0]   s;
    logic [8*VL-1:0] q;
  } exp_t;
  exp_t sb[$];
  int checks = 0, fails = 0;
  int ml[AD][VL], ql[AD][VL], el[AD][VL];
  logic [SW-1:0] qs[AD];
  int fv[8] = '{0, 4, -4, 12, -5, 20, 3, -12};
  int fe[8] = '{0, 1, 0, 2, -1, 3, 0, -1};
  always @(negedge clk) begin : mon
    exp_t e, g;
    if (rst_n) begin
      if (valid) begin
        checks++;
        g = {32'(cyc), done, sf, data};
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL unexpected_output cyc=%0d data=%h required none", cyc, data);
        end else begin
          e = sb.pop_front();
          if (g !== e) begin
            fails++;
            $display("FAIL out got cyc=%0d done=%b sf=%0d data=%h required cyc=%0d done=%b sf=%0d data=%h",
                     g.c, g.d, g.s, g.q, e.c, e.d, e.s, e.q);
          end
        end
      end else if (done) begin
        checks++;
        fails++;
        $display("FAIL done_without_valid got=1 required=0");
      end
    end
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string n, input logic [63:0] g, input logic [63:0] e);
    checks++;
    if (g !== e) begin
      fails++;
      $display("FAIL %s got=%h required=%h", n, g, e);
    end
  endtask
  // abort_w: window index at which reset is pulsed on beat 2 (-1 = never).
  task automatic run(input logic [1:0] m, input bit b2b, input bit stray, input int abort_w);
    int nw;
    bit qp;
    logic [AW*VL-1:0] mv, qv;
    logic [8*VL-1:0] qe;
    nw = m == 2'd2 ? TL : 2 * TL;
    mode = m;
    start = 1'b1;
    tick;
    start = 1'b0;
    mode = ~m;
    for (int w = 0; w < nw; w++) begin
      qp = m == 2'd2 || w >= TL;
      for (int b = 0; b < AD; b++) begin
        if (w == abort_w && b == 2) begin
          rst_n = 1'b0;
          #1;
          chk("rst_mid_valid", 64'(valid), 64'd0);
          chk("rst_mid_data", 64'(data), 64'd0);
          chk("rst_mid_sf", 64'(sf), 64'd0);
          chk("rst_mid_done", 64'(done), 64'd0);
          sb.delete();
          tick;
          rst_n = 1'b1;
          tick;
          return;
        end
        for (int i = 0; i < VL; i++) begin
          mv[i*AW +: AW] = AW'(ml[b][i]);
          qv[i*AW +: AW] = AW'(ql[b][i]);
          qe[i*8 +: 8]   = 8'(el[b][i]);
        end
        acc = qp ? qv : mv;
        start = (b == AD - 1 && b2b && w < nw - 1) || (stray && b == 3);
        if (qp) sb.push_back({32'(cyc + 2), w == nw - 1 && b == AD - 1, qs[b], qe});
        tick;
      end
      start = 1'b0;
      acc = {VL{24'h7FFFFF}};
      if (!b2b && w < nw - 1) begin
        tick;
        start = 1'b1;
        tick;
        start = 1'b0;
      end
    end
    repeat (4) tick;
  endtask
  task automatic fill_int8;
    for (int b = 0; b < AD; b++) begin
      for (int i = 0; i < VL; i++) begin
        ml[b][i] = i % 2 ? -b : b;
        ql[b][i] = fv[(b + i) % 8];
        el[b][i] = fe[(b + i) % 8];
      end
      ql[b][0] = 1000;  el[b][0] = 125;
      ql[b][1] = 1023;  el[b][1] = 127;
      ql[b][2] = -1024; el[b][2] = -128;
      qs[b] = 5'd3;
    end
    ml[2][3] = 1000;
  endtask
  task automatic fill_fives;
    for (int b = 0; b < AD; b++) begin
      for (int i = 0; i < VL; i++) begin
        ml[b][i] = 5; ql[b][i] = 5; el[b][i] = 5;
      end
      qs[b] = 5'd0;
    end
  endtask
  task automatic fill_int4;
    int qa[8] = '{100, -100, 200, -200, 7, 8, -8, -9};
    int ea[8] = '{6, -6, 7, -8, 0, 1, 0, -1};
    for (int b = 0; b < AD; b++) begin
      for (int i = 0; i < VL; i++) begin
        ml[b][i] = 5; ql[b][i] = qa[i]; el[b][i] = ea[i];
      end
      qs[b] = 5'd4;
    end
    ml[0][0] = 100;
    ml[4][5] = -7;
  endtask
  task automatic fill_vsq;
    for (int b = 0; b < AD; b++) begin
      for (int i = 0; i < VL; i++) begin
        ml[b][i] = 0; ql[b][i] = 0; el[b][i] = 0;
      end
      qs[b] = b % 2 ? 5'd0 : 5'd4;
      if (b % 2 == 0) begin
        ql[b][0] = 64; el[b][0] = 4;
        ql[b][1] = -3;
      end
    end
    ql[7][0] = -8388608; el[7][0] = -4;
    ql[7][1] = 8388607;  el[7][1] = 4;
    qs[7] = 5'd21;
  endtask
  initial begin : wd
    #200000;
    $display("FAIL timeout got=running required=finished");
    $fatal(1, "timeout");
  end
  initial begin
    tick;
    tick;
    chk("reset_valid", 64'(valid), 64'd0);
    chk("reset_data", 64'(data), 64'd0);
    chk("reset_sf", 64'(sf), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    rst_n = 1'b1;
    tick;
    fill_int8;  run(2'd0, 1'b0, 1'b0, -1);
    fill_fives; run(2'd1, 1'b0, 1'b0, -1);
    fill_int4;  run(2'd1, 1'b0, 1'b0, -1);
    fill_vsq;   run(2'd2, 1'b0, 1'b0, -1);
    fill_int8;  run(2'd0, 1'b1, 1'b0, -1);
    fill_int4;  run(2'd1, 1'b0, 1'b1, -1);
    fill_vsq;   run(2'd2, 1'b1, 1'b1, -1);
    fill_fives;
    for (int b = 0; b < AD; b++) begin
      for (int i = 0; i < VL; i++) begin
        ml[b][i] = 0; ql[b][i] = 0; el[b][i] = 0;
      end
      qs[b] = 5'd14;
    end
    ml[0][0] = 1 << 20;
    run(2'd0, 1'b0, 1'b0, TL + 1);
    fill_fives; run(2'd1, 1'b0, 1'b0, -1);
    repeat (10) tick;
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
